stmt_lowerer_call_arbiter: RTL

Round-robin scheduler that shares one side-effecting call channel (DPI / system-task style, one call outstanding) among `NUM_REQ` clocked requesters. It accepts one request at a time and issues it on the shared call port. It waits for the return, with a timeout, and routes the return value back to the originating requester. It sits between `always_ff` blocks that issue calls and the single call sink, and it exercises FSM, counter and handshake lowering in ingest tests.

---
 rtl/stmt_lowerer_call_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/stmt_lowerer_call_arbiter.sv
// Round-robin arbiter sharing one single-outstanding call channel among
// NUM_REQ requesters, with return routing, timeout abort and error count.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-requester request strobe (held until accepted)
//   req_data      : packed arguments, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     : one-hot accept, combinational, only in IDLE
//   rsp_valid     : one-hot one-cycle return strobe to the granted requester
//   rsp_data      : return value (0 when no rsp_valid bit is set)
//   call_valid    : call presented to the sink
//   call_id       : granted requester index
//   call_data     : latched argument
//   call_ready    : sink accepts the call
//   ret_valid     : sink return strobe
//   ret_data      : sink return value
//   timeout_err   : one-cycle pulse coincident with an aborted response
//   err_count     : saturating abort count
module stmt_lowerer_call_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          call_valid,
    output logic [$clog2(NUM_REQ)-1:0]    call_id,
    output logic [DATA_WIDTH-1:0]         call_data,
    input  logic                          call_ready,
    input  logic                          ret_valid,
    input  logic [DATA_WIDTH-1:0]         ret_data,
    output logic                          timeout_err,
    output logic [7:0]                    err_count
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);
    localparam logic [ID_W:0] N_EXT = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] ID_MAX = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       grant_id;
    logic [DATA_WIDTH-1:0] arg;
    logic [DATA_WIDTH-1:0] ret_val;
    logic [7:0]            timer;

    logic [2*NUM_REQ-1:0]  dbl;
    logic [NUM_REQ-1:0]    rot;
    logic [ID_W-1:0]       off;
    logic [ID_W:0]         sum;
    logic [ID_W-1:0]       pick;
    logic                  any;

    // Rotate the request vector so bit k is requester (rr_ptr+k) mod NUM_REQ,
    // then take the lowest set offset and map it back to an index.
    always_comb begin
        dbl = {req_valid, req_valid} >> rr_ptr;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = ID_W'(k);
                any = 1'b1;
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        pick = sum[ID_W-1:0];
    end

    assign req_ready  = (state == IDLE && any && !rst)
                      ? (NUM_REQ'(1) << pick) : '0;
    assign call_valid = (state == ISSUE);
    assign call_id    = call_valid ? grant_id : '0;
    assign call_data  = call_valid ? arg : '0;
    assign rsp_valid  = (state == RESPOND)
                      ? (NUM_REQ'(1) << grant_id) : '0;
    assign rsp_data   = (state == RESPOND) ? ret_val : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            arg         <= '0;
            ret_val     <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
            err_count   <= '0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        grant_id <= pick;
                        arg      <= req_data[pick*DATA_WIDTH +: DATA_WIDTH];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (call_ready) begin
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A return arriving in the expiry cycle takes priority.
                    if (ret_valid) begin
                        ret_val <= ret_data;
                        state   <= RESPOND;
                    end else if (timer == T_LAST) begin
                        ret_val     <= '0;
                        timeout_err <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        state <= RESPOND;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESPOND: begin
                    rr_ptr <= (grant_id == ID_MAX) ? '0 : grant_id + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
